// File: rtl/fetch_stage.sv
// Instruction fetch stage for a 16-bit Thumb pipeline.
// Owns the fetch PC, drives a synchronous instruction memory with one cycle of
// read latency, holds the current instruction while the controller stalls, and
// inserts a single bubble on every branch redirect.
// Optional build macro: FETCH_STALL_COUNTER_EN adds a saturating stall counter
// on stall_count_o.
module fetch_stage #(
    parameter int unsigned          PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [15:0]         imem_data_i,
    output logic [15:0]         instruction_o,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                instr_valid_o,
    output logic                prefix_32_o
`ifdef FETCH_STALL_COUNTER_EN
    ,
    output logic [31:0]         stall_count_o
`endif
);

    // Halfword-aligned reset address; bit 0 of the parameter is ignored.
    localparam logic [PC_WIDTH-1:0] RESET_ADDR = RESET_PC & ~PC_WIDTH'(1);
    // Thumb NOP: presented whenever there is no real instruction.
    localparam logic [15:0]         NOP_INSTR  = 16'hBF00;

    logic [PC_WIDTH-1:0] fetch_pc_q;
    logic [PC_WIDTH-1:0] resp_pc_q;
    logic                resp_valid_q;
    logic                hold_valid_q;
    logic [15:0]         hold_instr_q;
    logic [PC_WIDTH-1:0] target_aligned;

    assign target_aligned = branch_target_i & ~PC_WIDTH'(1);

    // Fetch/response state: reset, then redirect, then stall, then advance.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q   <= RESET_ADDR;
            resp_pc_q    <= RESET_ADDR;
            resp_valid_q <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
        end else if (branch_taken_i) begin
            // Redirect wins over a stall; any held instruction is stale.
            fetch_pc_q   <= target_aligned;
            resp_valid_q <= 1'b0;
            hold_valid_q <= 1'b0;
        end else if (stall_i) begin
            // Capture the live response once; the memory keeps returning
            // fetch_pc_q's data, which is what the release cycle needs next.
            if (!hold_valid_q && resp_valid_q) begin
                hold_instr_q <= imem_data_i;
                hold_valid_q <= 1'b1;
            end
        end else begin
            resp_pc_q    <= fetch_pc_q;
            resp_valid_q <= 1'b1;
            hold_valid_q <= 1'b0;
            fetch_pc_q   <= fetch_pc_q + PC_WIDTH'(2);
        end
    end

    assign imem_addr_o   = fetch_pc_q;
    assign pc_o          = resp_pc_q;
    assign instr_valid_o = resp_valid_q;

    // Instruction mux and 32-bit prefix detect (opcodes 11101, 11110, 11111).
    always_comb begin
        instruction_o = imem_data_i;
        if (!resp_valid_q) begin
            instruction_o = NOP_INSTR;
        end else if (hold_valid_q) begin
            instruction_o = hold_instr_q;
        end
        prefix_32_o = resp_valid_q
                    && (instruction_o[15:13] == 3'b111)
                    && (instruction_o[12:11] != 2'b00);
    end

`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0] stall_count_q;

    // Count genuine stall cycles (not overridden by reset or redirect), saturating.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_count_q <= '0;
        end else if (stall_i && !branch_taken_i && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count_o = stall_count_q;
`else
    // No stall counter in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run checked against an instruction-stream reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        stall = 1'b0;
    logic        br    = 1'b0;
    logic [31:0] tgt   = '0;

    logic [31:0] addr_a, pc_a, addr_b, pc_b;
    logic [15:0] data_a = '0, instr_a, data_b = '0, instr_b;
    logic        valid_a, pre_a, valid_b, pre_b;
`ifdef FETCH_STALL_COUNTER_EN
    logic [31:0] scount_a, scount_b;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: state of the instruction stream seen by the controller.
    logic        m_valid = 1'b0, mb_valid = 1'b0;
    logic [31:0] m_pc = '0, m_next = 32'h100, mb_pc = '0, mb_next = 32'hFFFF_FFFC;
    logic [31:0] m_scount = '0;

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0100)) dut (
        .clk_i(clk), .reset_i(rst), .stall_i(stall), .branch_taken_i(br),
        .branch_target_i(tgt), .imem_addr_o(addr_a), .imem_data_i(data_a),
        .instruction_o(instr_a), .pc_o(pc_a), .instr_valid_o(valid_a),
        .prefix_32_o(pre_a)
`ifdef FETCH_STALL_COUNTER_EN
        , .stall_count_o(scount_a)
`endif
    );

    fetch_stage #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk_i(clk), .reset_i(rst), .stall_i(stall), .branch_taken_i(br),
        .branch_target_i(tgt), .imem_addr_o(addr_b), .imem_data_i(data_b),
        .instruction_o(instr_b), .pc_o(pc_b), .instr_valid_o(valid_b),
        .prefix_32_o(pre_b)
`ifdef FETCH_STALL_COUNTER_EN
        , .stall_count_o(scount_b)
`endif
    );

    function automatic logic [15:0] mem_word(input logic [31:0] a);
        if (a == 32'h110) return 16'hF000;
        if (a == 32'h112) return 16'hE7FE;
        return a[15:0];
    endfunction

    // Synchronous instruction memories, one-cycle read latency.
    always @(posedge clk) begin
        data_a <= mem_word(addr_a);
        data_b <= mem_word(addr_b);
    end

    // Drive one cycle of controller inputs, advance the reference model, settle.
    task automatic step(input logic s, input logic b, input logic [31:0] t, input logic r);
        rst = r; stall = s; br = b; tgt = t;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;  m_next = 32'h100;
            mb_valid = 1'b0; mb_next = 32'hFFFF_FFFC;
            m_scount = '0;
        end else if (b) begin
            m_valid = 1'b0;  m_next = t & ~32'd1;
            mb_valid = 1'b0; mb_next = t & ~32'd1;
        end else if (s) begin
            if (m_scount != 32'hFFFF_FFFF) m_scount = m_scount + 1;
        end else begin
            m_valid = 1'b1;  m_pc = m_next;   m_next = m_next + 32'd2;
            mb_valid = 1'b1; mb_pc = mb_next; mb_next = mb_next + 32'd2;
        end
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_a); end
        checks++; if (instr_a !== 16'hBF00) begin errors++; $display("FAIL reset_instr: got %h expected bf00", instr_a); end
        checks++; if (pre_a !== 1'b0) begin errors++; $display("FAIL reset_prefix: got %b expected 0", pre_a); end
        checks++; if (addr_a !== 32'h100) begin errors++; $display("FAIL reset_addr: got %h expected 00000100", addr_a); end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 0);
            checks++; if (valid_a !== 1'b1 || pc_a !== 32'h100 + 2*i || instr_a !== 16'(32'h100 + 2*i)) begin
                errors++; $display("FAIL seq_fetch[%0d]: got v=%b pc=%h i=%h expected v=1 pc=%h", i, valid_a, pc_a, instr_a, 32'h100 + 2*i);
            end
        end
    endtask

    task automatic test_stall();
        checks++; if (pc_a !== 32'h104 || instr_a !== 16'h0104 || addr_a !== 32'h106) begin
            errors++; $display("FAIL stall_pre: got pc=%h i=%h a=%h expected 104/0104/106", pc_a, instr_a, addr_a);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, '0, 0);
            checks++; if (valid_a !== 1'b1 || pc_a !== 32'h104 || instr_a !== 16'h0104 || addr_a !== 32'h106) begin
                errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h i=%h a=%h expected 1/104/0104/106", i, valid_a, pc_a, instr_a, addr_a);
            end
        end
`ifdef FETCH_STALL_COUNTER_EN
        checks++; if (scount_a !== 32'd3) begin errors++; $display("FAIL stall_count: got %0d expected 3", scount_a); end
`endif
        for (int i = 0; i < 2; i++) begin
            step(0, 0, '0, 0);
            checks++; if (valid_a !== 1'b1 || pc_a !== 32'h106 + 2*i || instr_a !== 16'(32'h106 + 2*i)) begin
                errors++; $display("FAIL stall_release[%0d]: got pc=%h i=%h expected pc=%h", i, pc_a, instr_a, 32'h106 + 2*i);
            end
        end
    endtask

    task automatic test_branch();
        step(0, 1, 32'h201, 0);
        checks++; if (valid_a !== 1'b0 || instr_a !== 16'hBF00 || pre_a !== 1'b0 || addr_a !== 32'h200) begin
            errors++; $display("FAIL branch_bubble: got v=%b i=%h p=%b a=%h expected 0/bf00/0/200", valid_a, instr_a, pre_a, addr_a);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, '0, 0);
            checks++; if (valid_a !== 1'b1 || pc_a !== 32'h200 + 2*i || instr_a !== 16'(32'h200 + 2*i)) begin
                errors++; $display("FAIL branch_target[%0d]: got v=%b pc=%h i=%h expected pc=%h", i, valid_a, pc_a, instr_a, 32'h200 + 2*i);
            end
        end
    endtask

    task automatic test_branch_in_stall();
        step(1, 0, '0, 0);
        step(1, 1, 32'h300, 0);
        checks++; if (valid_a !== 1'b0 || instr_a !== 16'hBF00) begin
            errors++; $display("FAIL stall_branch_bubble: got v=%b i=%h expected 0/bf00", valid_a, instr_a);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, '0, 0);
            checks++; if (valid_a !== 1'b1 || pc_a !== 32'h300 + 2*i || instr_a !== 16'(32'h300 + 2*i)) begin
                errors++; $display("FAIL stall_branch_target[%0d]: got v=%b pc=%h i=%h expected pc=%h", i, valid_a, pc_a, instr_a, 32'h300 + 2*i);
            end
        end
    endtask

    task automatic test_prefix();
        logic [31:0] pc;
        step(0, 0, '0, 1);
        for (int i = 0; i < 11; i++) begin
            step(0, 0, '0, 0);
            pc = 32'h100 + 32'(2*i);
            checks++; if (pc_a !== pc || instr_a !== mem_word(pc) || pre_a !== (pc == 32'h110)) begin
                errors++; $display("FAIL prefix[%0d]: got pc=%h i=%h p=%b expected pc=%h i=%h p=%b", i, pc_a, instr_a, pre_a, pc, mem_word(pc), pc == 32'h110);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFFC; exp_pc[1] = 32'hFFFF_FFFE; exp_pc[2] = 32'h0000_0000;
        step(0, 0, '0, 1);
        checks++; if (addr_b !== 32'hFFFF_FFFC || valid_b !== 1'b0) begin
            errors++; $display("FAIL wrap_reset: got a=%h v=%b expected fffffffc/0", addr_b, valid_b);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, '0, 0);
            checks++; if (valid_b !== 1'b1 || pc_b !== exp_pc[i] || instr_b !== exp_pc[i][15:0]) begin
                errors++; $display("FAIL wrap_seq[%0d]: got v=%b pc=%h i=%h expected pc=%h", i, valid_b, pc_b, instr_b, exp_pc[i]);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        step(0, 0, '0, 0);
        step(1, 0, '0, 0);
        step(1, 0, '0, 0);
        step(1, 0, '0, 1);
        checks++; if (valid_a !== 1'b0 || instr_a !== 16'hBF00 || addr_a !== 32'h100) begin
            errors++; $display("FAIL midstall_reset: got v=%b i=%h a=%h expected 0/bf00/100", valid_a, instr_a, addr_a);
        end
        step(0, 0, '0, 0);
        checks++; if (valid_a !== 1'b1 || pc_a !== 32'h100 || instr_a !== 16'h0100) begin
            errors++; $display("FAIL midstall_restart: got v=%b pc=%h i=%h expected 1/100/0100", valid_a, pc_a, instr_a);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_i;
        logic        exp_p;
        step(0, 0, '0, 1);
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 3) == 0, ($urandom % 8) == 0, $urandom, ($urandom % 50) == 0);
            exp_i = m_valid ? mem_word(m_pc) : 16'hBF00;
            exp_p = m_valid && (exp_i[15:11] >= 5'b11101);
            checks++; if (valid_a !== m_valid || instr_a !== exp_i || pre_a !== exp_p || addr_a !== m_next) begin
                errors++; $display("FAIL rnd_a[%0d]: got v=%b i=%h p=%b a=%h expected v=%b i=%h p=%b a=%h", i, valid_a, instr_a, pre_a, addr_a, m_valid, exp_i, exp_p, m_next);
            end
            if (m_valid) begin
                checks++; if (pc_a !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc_a, m_pc); end
            end
            checks++; if (valid_b !== mb_valid || addr_b !== mb_next || (mb_valid && pc_b !== mb_pc)) begin
                errors++; $display("FAIL rnd_b[%0d]: got v=%b pc=%h a=%h expected v=%b pc=%h a=%h", i, valid_b, pc_b, addr_b, mb_valid, mb_pc, mb_next);
            end
`ifdef FETCH_STALL_COUNTER_EN
            checks++; if (scount_a !== m_scount) begin errors++; $display("FAIL rnd_scount[%0d]: got %0d expected %0d", i, scount_a, m_scount); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_branch();
        test_branch_in_stall();
        test_prefix();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
